uart_core_param: RTL

UART_CORE_PARAM -- requirements
Module: uart_core_param

---
 rtl/uart_core_param.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: parameterised full-duplex UART core.
//
// Frame format: start bit (0), DATA_BITS data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT
// clk cycles. The transmitter and the receiver are independent FSMs.
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          synchronous active-low reset
//   tx_data        word to send, latched when tx_valid && tx_ready
//   tx_valid       transmit request
//   tx_ready       transmitter idle
//   tx             serial output, idle high
//   rx             serial input, asynchronous to clk
//   rx_data        last delivered receive word
//   rx_valid       rx_data holds a frame not yet acknowledged
//   rx_ack         consumer acknowledge; clears rx_valid and all flags
//   rx_parity_err  parity mismatch in the held frame
//   rx_frame_err   a stop bit of the held frame was sampled low
//   rx_overrun     sticky: a frame completed while rx_valid was set
//
// Both FSMs use the same state encoding:
//   state    | meaning
//   S_IDLE   | line idle; TX waits for a request, RX waits for a falling edge
//   S_START  | start bit; RX checks it again at mid-bit to reject glitches
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (never entered when PARITY_EN=0)
//   S_STOP   | stop bit(s)

module uart_core_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = (PARITY_EN != 0);
    localparam logic        ODD        = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state, tx_state_nx;
    logic [15:0]            tx_cnt, tx_cnt_nx;
    logic [2:0]             tx_idx, tx_idx_nx;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_nx;
    logic                   tx_par, tx_par_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_shift <= tx_shift_nx;
            tx_par   <= tx_par_nx;
        end
    end

    // Bit timer is a down-counter; a bit ends when it reaches zero.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        tx_par_nx   = tx_par;
        case (tx_state)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_state_nx = S_START;
                    tx_cnt_nx   = BIT_LAST;
                    tx_idx_nx   = '0;
                    tx_shift_nx = tx_data;
                    tx_par_nx   = (^tx_data) ^ ODD;
                end
            end
            default: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end else begin
                    tx_cnt_nx = BIT_LAST;
                    case (tx_state)
                        S_START: begin
                            tx_state_nx = S_DATA;
                            tx_idx_nx   = '0;
                        end
                        S_DATA: begin
                            tx_shift_nx = tx_shift >> 1;
                            if (tx_idx == DATA_LAST) begin
                                tx_idx_nx   = '0;
                                tx_state_nx = HAS_PARITY ? S_PARITY : S_STOP;
                            end else begin
                                tx_idx_nx = tx_idx + 3'd1;
                            end
                        end
                        S_PARITY: begin
                            tx_state_nx = S_STOP;
                            tx_idx_nx   = '0;
                        end
                        S_STOP: begin
                            if (tx_idx == STOP_LAST) begin
                                tx_state_nx = S_IDLE;
                                tx_cnt_nx   = '0;
                                tx_idx_nx   = '0;
                            end else begin
                                tx_idx_nx = tx_idx + 3'd1;
                            end
                        end
                        default: tx_state_nx = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Line level is a pure decode of registered state, so it changes
    // exactly on the edge that changes the state.
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift[0];
            S_PARITY: tx = tx_par;
            default:  tx = 1'b1;
        endcase
    end

    assign tx_ready = (tx_state == S_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    // rx_prev keeps the previous synchronized level for edge detection;
    // after a frame error the line must go high again before a new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    state_t                 rx_state, rx_state_nx;
    logic [15:0]            rx_cnt, rx_cnt_nx;
    logic [2:0]             rx_idx, rx_idx_nx;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_nx;
    logic                   rx_par_bit, rx_par_bit_nx;
    logic                   rx_ferr, rx_ferr_nx;
    logic                   frame_done, frame_perr, frame_ferr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_state   <= rx_state_nx;
            rx_cnt     <= rx_cnt_nx;
            rx_idx     <= rx_idx_nx;
            rx_shift   <= rx_shift_nx;
            rx_par_bit <= rx_par_bit_nx;
            rx_ferr    <= rx_ferr_nx;
        end
    end

    // The first timeout lands at the middle of the start bit; every later
    // one is a full bit period on, so all samples fall at mid-bit.
    always_comb begin
        rx_state_nx   = rx_state;
        rx_cnt_nx     = rx_cnt;
        rx_idx_nx     = rx_idx;
        rx_shift_nx   = rx_shift;
        rx_par_bit_nx = rx_par_bit;
        rx_ferr_nx    = rx_ferr;
        frame_done    = 1'b0;
        frame_perr    = 1'b0;
        frame_ferr    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_nx = S_START;
                    rx_cnt_nx   = HALF_LAST;
                end
            end
            default: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end else begin
                    rx_cnt_nx = BIT_LAST;
                    case (rx_state)
                        S_START: begin
                            if (rx_sync) begin
                                rx_state_nx = S_IDLE;
                                rx_cnt_nx   = '0;
                            end else begin
                                rx_state_nx = S_DATA;
                                rx_idx_nx   = '0;
                                rx_ferr_nx  = 1'b0;
                            end
                        end
                        S_DATA: begin
                            rx_shift_nx = {rx_sync, rx_shift[DATA_BITS-1:1]};
                            if (rx_idx == DATA_LAST) begin
                                rx_idx_nx   = '0;
                                rx_state_nx = HAS_PARITY ? S_PARITY : S_STOP;
                            end else begin
                                rx_idx_nx = rx_idx + 3'd1;
                            end
                        end
                        S_PARITY: begin
                            rx_par_bit_nx = rx_sync;
                            rx_state_nx   = S_STOP;
                            rx_idx_nx     = '0;
                        end
                        S_STOP: begin
                            if (!rx_sync) begin
                                rx_ferr_nx = 1'b1;
                            end
                            if (rx_idx == STOP_LAST) begin
                                rx_state_nx = S_IDLE;
                                rx_cnt_nx   = '0;
                                rx_idx_nx   = '0;
                                frame_done  = 1'b1;
                                frame_ferr  = rx_ferr | ~rx_sync;
                                frame_perr  = HAS_PARITY &&
                                              (((^rx_shift) ^ ODD) != rx_par_bit);
                            end else begin
                                rx_idx_nx = rx_idx + 3'd1;
                            end
                        end
                        default: rx_state_nx = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Delivery registers. An ack in the same cycle as a completion is
    // applied first, so the new frame loads instead of overrunning.
    logic ack_eff;
    assign ack_eff = rx_ack && rx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (ack_eff) begin
                rx_valid      <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_frame_err  <= 1'b0;
                rx_overrun    <= 1'b0;
            end
            if (frame_done) begin
                if (!rx_valid || ack_eff) begin
                    rx_data       <= rx_shift;
                    rx_parity_err <= frame_perr;
                    rx_frame_err  <= frame_ferr;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule
